// File: rtl/y86_pkg.sv
// Shared Y86 definitions: instruction codes, register sentinel,
// encoder state encoding and the per-icode instruction length.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] REG_NONE = 4'hF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_e;

    // Zero marks an illegal icode.
    function automatic logic [3:0] instr_len(input logic [3:0] icode);
        logic [3:0] len;
        unique case (icode)
            I_HALT, I_NOP, I_RET:               len = 4'd1;
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ:   len = 4'd2;
            I_JXX, I_CALL:                      len = 4'd9;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:       len = 4'd10;
            default:                            len = 4'd0;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/y86_instr_len.sv
// Combinational icode -> instruction length lookup, shared with fetch.
module y86_instr_len
    import y86_pkg::*;
(
    input  logic [3:0] icode_i,
    output logic [3:0] len_o,
    output logic       valid_o
);

    assign len_o   = instr_len(icode_i);
    assign valid_o = (len_o != 4'd0);

endmodule

// File: rtl/y86_instr_encoder.sv
// Serialises decoded Y86 instructions into byte-wide imem writes
// at a running write pointer, one byte per cycle.
module y86_instr_encoder
    import y86_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int MEM_BYTES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        icode,
    input  logic [3:0]        ifun,
    input  logic [3:0]        rA,
    input  logic [3:0]        rB,
    input  logic [63:0]       valc,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] next_pc
);

    localparam logic [ADDR_W:0] MEM_END = (ADDR_W+1)'(MEM_BYTES);

    state_e            state_q, state_d;
    logic [3:0]        idx_q, len_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   pc_q;
    logic [79:0]       img_q, img;
    logic              err_q;

    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic              done_q, done_d;

    logic [3:0]        len;
    logic              len_ok;
    logic [ADDR_W:0]   end_pc;
    logic              accept, start, last;
    logic [3:0]        ra_f, rb_f;

    y86_instr_len u_len (
        .icode_i (icode),
        .len_o   (len),
        .valid_o (len_ok)
    );

    // Pointer is one bit wider so a completely full imem is representable.
    assign end_pc   = pc_q + (ADDR_W+1)'(len);
    assign in_ready = (state_q == ST_IDLE) && !addr_load;
    assign accept   = in_valid && in_ready;
    assign start    = accept && len_ok && (end_pc <= MEM_END);
    assign last     = (idx_q == len_q);

    assign ra_f = (icode == I_IRMOVQ) ? REG_NONE : rA;
    assign rb_f = (icode == I_PUSHQ || icode == I_POPQ) ? REG_NONE : rB;

    always_comb begin
        img       = '0;
        img[7:0]  = {icode, ifun};
        unique case (icode)
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
                img[15:8]  = {ra_f, rb_f};
                img[79:16] = valc;
            end
            I_JXX, I_CALL: img[71:8] = valc;
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: img[15:8] = {ra_f, rb_f};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start) state_d = ST_EMIT;
            ST_EMIT: if (last)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Byte 0 is registered at accept; idx_q then names the next byte.
    always_comb begin
        we_d   = 1'b0;
        addr_d = addr_q;
        data_d = data_q;
        done_d = 1'b0;
        if (state_q == ST_IDLE && start) begin
            we_d   = 1'b1;
            addr_d = pc_q[ADDR_W-1:0];
            data_d = img[7:0];
            done_d = (len == 4'd1);
        end else if (state_q == ST_EMIT && !last) begin
            we_d   = 1'b1;
            addr_d = base_q + ADDR_W'(idx_q);
            data_d = img_q[{idx_q, 3'b000} +: 8];
            done_d = (idx_q == len_q - 4'd1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            done_q <= 1'b0;
        end else begin
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
            done_q <= done_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            len_q  <= '0;
            base_q <= '0;
            img_q  <= '0;
            pc_q   <= '0;
            err_q  <= 1'b0;
        end else if (state_q == ST_IDLE) begin
            if (addr_load) begin
                pc_q  <= {1'b0, addr_in};
                err_q <= 1'b0;
            end else if (start) begin
                base_q <= pc_q[ADDR_W-1:0];
                len_q  <= len;
                img_q  <= img;
                idx_q  <= 4'd1;
            end else if (accept) begin
                err_q <= 1'b1;
            end
        end else begin
            if (last) pc_q <= {1'b0, base_q} + (ADDR_W+1)'(len_q);
            else      idx_q <= idx_q + 4'd1;
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = data_q;
    assign done      = done_q;
    assign error     = err_q;
    assign next_pc   = pc_q[ADDR_W-1:0];

endmodule
